// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmitter.
// Optional parity build: define UART_TX_PARITY_EN.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 9600;
  localparam int DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick in the last cycle of every bit.
// Held at zero while disabled; cleared when a frame starts.
import uart_pkg::*;

module uart_baud_tick #(
  parameter int DIV = 5208
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = en_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || !en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with rising-edge request and done pulse.
// Define UART_TX_PARITY_EN to append an even-parity bit after D7.
import uart_pkg::*;

module uart_tx_8n1 #(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic       sysclk,
  input  logic       nrst,
  input  logic [7:0] datain,
  input  logic       flag_tx,
  output logic       rs232_tx,
  output logic       tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int IW = cnt_w(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  state_e               state_q;
  state_e               state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        idx_d;
  logic                 flag_q;
  logic                 req;
  logic                 tick;
  logic                 busy;

  // flag_q resets high so a request held through reset is not an edge
  assign req  = flag_tx & ~flag_q;
  assign busy = (state_q != IDLE);

  uart_baud_tick #(
    .DIV (BAUD_DIV)
  ) u_tick (
    .clk_i  (sysclk),
    .rst_i  (nrst),
    .clr_i  (req & ~busy),
    .en_i   (busy),
    .tick_o (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par_q;
  logic par_d;

  always_comb begin
    par_d = par_q;
    if (state_q == IDLE && req) begin
      par_d = ^datain;
    end
  end

  always_ff @(posedge sysclk) begin
    if (nrst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_ff @(posedge sysclk) begin
    if (nrst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      flag_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      flag_q  <= flag_tx;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = START;
          shift_d = datain;
          idx_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rs232_tx = 1'b1;
    tx_done  = 1'b0;
    unique case (state_q)
      IDLE:   rs232_tx = 1'b1;
      START:  rs232_tx = 1'b0;
      DATA:   rs232_tx = shift_q[idx_q];
`ifdef UART_TX_PARITY_EN
      PARITY: rs232_tx = par_q;
`else
      PARITY: rs232_tx = 1'b1;
`endif
      STOP: begin
        rs232_tx = 1'b1;
        tx_done  = tick;
      end
      default: rs232_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1 with a shortened bit period.
// Frame vectors are {stop, D7..D0, start}, hand-computed.
module tb_uart_tx_8n1;

  localparam int CF  = 160;
  localparam int BR  = 10;
  localparam int DIV = CF / BR;
  localparam int FL  = 10 * DIV;

  logic       sysclk = 1'b0;
  logic       nrst = 1'b1;
  logic [7:0] datain = 8'h00;
  logic       flag_tx = 1'b1;
  logic       rs232_tx;
  logic       tx_done;

  int checks = 0;
  int fails  = 0;

  uart_tx_8n1 #(
    .CLK_FREQ (CF),
    .BAUD     (BR)
  ) dut (
    .sysclk   (sysclk),
    .nrst     (nrst),
    .datain   (datain),
    .flag_tx  (flag_tx),
    .rs232_tx (rs232_tx),
    .tx_done  (tx_done)
  );

  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller leaves flag_tx low; this raises it and follows one frame.
  task automatic run_frame(input string tag,
                           input logic [9:0] exp,
                           input int drop_k,
                           input bit glitch);
    int bad;
    int dones;
    int done_at;
    bad = 0;
    dones = 0;
    done_at = -1;
    chk({tag, "_pre_idle"}, 32'(rs232_tx), 32'd1);
    flag_tx = 1'b1;
    step();
    chk({tag, "_start_edge"}, 32'(rs232_tx), 32'd0);
    for (int k = 0; k < FL; k++) begin
      if (rs232_tx !== exp[k / DIV]) bad++;
      if (k % DIV == DIV / 2)
        chk($sformatf("%s_bit%0d", tag, k / DIV),
            32'(rs232_tx), 32'(exp[k / DIV]));
      if (tx_done === 1'b1) begin
        dones++;
        done_at = k;
      end
      if (k == 2) datain = ~datain;
      if (k == drop_k) flag_tx = 1'b0;
      if (glitch) begin
        if (k == 3 * DIV) flag_tx = 1'b0;
        if (k == 3 * DIV + 2) flag_tx = 1'b1;
        if (k == 3 * DIV + 4) flag_tx = 1'b0;
      end
      step();
    end
    chk({tag, "_bad_cycles"}, 32'(bad), 32'd0);
    chk({tag, "_done_count"}, 32'(dones), 32'd1);
    chk({tag, "_done_pos"}, 32'(done_at), 32'(FL - 1));
    chk({tag, "_post_idle"}, 32'(rs232_tx), 32'd1);
  endtask

  task automatic idle_for(input string tag, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (rs232_tx !== 1'b1 || tx_done !== 1'b0) bad++;
      step();
    end
    chk({tag, "_idle"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int bad;
    int dones;

    // reset held 3 cycles with request high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_line", 32'(rs232_tx), 32'd1);
      chk("rst_done", 32'(tx_done), 32'd0);
    end
    nrst = 1'b0;
    idle_for("rst_release_high", 4);
    flag_tx = 1'b0;
    step();

    // first frame, request high 6 cycles, datain disturbed mid-frame
    datain = 8'h5A;
    run_frame("f5A", 10'b1010110100, 5, 1'b0);

    // back-to-back with a long-held request
    datain = 8'hA5;
    run_frame("fA5", 10'b1101001010, -1, 1'b0);
    idle_for("fA5_long", 8 * DIV);
    flag_tx = 1'b0;
    step();

    // extra edges while busy
    datain = 8'h3C;
    run_frame("f3C", 10'b1001111000, 5, 1'b1);
    step();

    // reset during D3
    datain = 8'hC3;
    flag_tx = 1'b1;
    step();
    chk("mid_start", 32'(rs232_tx), 32'd0);
    dones = 0;
    for (int k = 0; k < 4 * DIV + DIV / 2; k++) begin
      if (tx_done === 1'b1) dones++;
      if (k == 3) flag_tx = 1'b0;
      step();
    end
    chk("mid_d3", 32'(rs232_tx), 32'd0);
    nrst = 1'b1;
    step();
    chk("mid_rst_line", 32'(rs232_tx), 32'd1);
    chk("mid_rst_done", 32'(tx_done), 32'd0);
    nrst = 1'b0;
    bad = 0;
    for (int k = 0; k < 2 * DIV; k++) begin
      if (tx_done === 1'b1) dones++;
      if (rs232_tx !== 1'b1) bad++;
      step();
    end
    chk("mid_no_done", 32'(dones), 32'd0);
    chk("mid_idle", 32'(bad), 32'd0);

    datain = 8'h00;
    run_frame("f00", 10'b1000000000, 3, 1'b0);
    step();

    // request and reset in the same cycle
    flag_tx = 1'b1;
    nrst = 1'b1;
    step();
    chk("rr_line", 32'(rs232_tx), 32'd1);
    nrst = 1'b0;
    idle_for("rr_after", 6);
    flag_tx = 1'b0;
    step();

    datain = 8'hFF;
    run_frame("fFF", 10'b1111111110, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
